// File: rtl/morse_keyer.sv
// morse_keyer: turns a raw Morse key into dot/dash/letter-gap/word-gap symbols
// for a 2-bit symbol FIFO, and a raw delete button into single delete strobes.
// Optional sidetone output enabled by defining MORSE_KEYER_SIDETONE_EN
// (adds parameter TONE_HALF_CYCLES); otherwise tone is tied low.
module morse_keyer #(
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int DOT_MAX_CYCLES    = 12500000,
    parameter int LETTER_GAP_CYCLES = 25000000,
    parameter int WORD_GAP_CYCLES   = 75000000,
    parameter int CNT_W             = 27
`ifdef MORSE_KEYER_SIDETONE_EN
    ,
    parameter int TONE_HALF_CYCLES  = 25000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    input  logic       del_key,
    input  logic       fifo_full,
    input  logic       fifo_empty,
    output logic       sym_we,
    output logic [1:0] sym_data,
    output logic       sym_del,
    output logic       drop,
    output logic       tone
);

    localparam logic [1:0] SYM_DOT    = 2'b00;
    localparam logic [1:0] SYM_DASH   = 2'b01;
    localparam logic [1:0] SYM_LETTER = 2'b10;
    localparam logic [1:0] SYM_WORD   = 2'b11;

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOT_MAX     = CNT_W'(DOT_MAX_CYCLES);
    localparam logic [CNT_W-1:0] LETTER_LAST = CNT_W'(LETTER_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] WORD_LAST   = CNT_W'(WORD_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    // synchronisers
    logic key_s1_q, key_s2_q;
    logic del_s1_q, del_s2_q;

    // debouncers
    logic            key_db_q, key_db_d;
    logic [DB_W-1:0] key_dbc_q, key_dbc_d;
    logic            del_db_q, del_db_d;
    logic [DB_W-1:0] del_dbc_q, del_dbc_d;
    logic            del_prev_q;

    // keying FSM
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gap_flag_q, gap_flag_d;
    logic             emit;
    logic [1:0]       emit_sym;

    // output strobes
    logic       sym_we_q, sym_we_d;
    logic [1:0] sym_data_q, sym_data_d;
    logic       sym_del_q, sym_del_d;
    logic       drop_q, drop_d;
    logic       del_pend_q, del_pend_d;
    logic       del_rise;

    // Two-flop synchronisers for the asynchronous key and delete inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_s1_q <= 1'b0;
            key_s2_q <= 1'b0;
            del_s1_q <= 1'b0;
            del_s2_q <= 1'b0;
        end else begin
            key_s1_q <= key;
            key_s2_q <= key_s1_q;
            del_s1_q <= del_key;
            del_s2_q <= del_s1_q;
        end
    end

    // Debounce: flip the level only after DEBOUNCE_CYCLES consecutive differing cycles
    always_comb begin
        key_db_d  = key_db_q;
        key_dbc_d = '0;
        if (key_s2_q != key_db_q) begin
            if (key_dbc_q == DB_LAST) begin
                key_db_d = key_s2_q;
            end else begin
                key_dbc_d = key_dbc_q + DB_W'(1);
            end
        end

        del_db_d  = del_db_q;
        del_dbc_d = '0;
        if (del_s2_q != del_db_q) begin
            if (del_dbc_q == DB_LAST) begin
                del_db_d = del_s2_q;
            end else begin
                del_dbc_d = del_dbc_q + DB_W'(1);
            end
        end
    end

    // Next-state logic: classify presses and time releases into gap symbols
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gap_flag_d = gap_flag_q;
        emit       = 1'b0;
        emit_sym   = SYM_DOT;
        case (state_q)
            IDLE: begin
                if (key_db_q) begin
                    state_d = PRESS;
                    cnt_d   = '0;
                end
            end
            PRESS: begin
                if (!key_db_q) begin
                    emit       = 1'b1;
                    emit_sym   = (cnt_q < DOT_MAX) ? SYM_DOT : SYM_DASH;
                    state_d    = GAP;
                    cnt_d      = '0;
                    gap_flag_d = 1'b0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (key_db_q) begin
                    // a new press abandons the partial gap without a symbol
                    state_d = PRESS;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == WORD_LAST) begin
                        emit     = 1'b1;
                        emit_sym = SYM_WORD;
                        state_d  = IDLE;
                        cnt_d    = '0;
                    end else if (cnt_q == LETTER_LAST && !gap_flag_q) begin
                        emit       = 1'b1;
                        emit_sym   = SYM_LETTER;
                        gap_flag_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Strobe arbitration: writes win over deletes, a colliding delete waits one cycle
    always_comb begin
        sym_we_d   = emit & ~fifo_full;
        drop_d     = emit & fifo_full;
        sym_data_d = sym_we_d ? emit_sym : 2'b00;
        del_rise   = del_db_q & ~del_prev_q;
        sym_del_d  = 1'b0;
        del_pend_d = 1'b0;
        if (del_rise || del_pend_q) begin
            if (sym_we_d) begin
                del_pend_d = 1'b1;
            end else if (!fifo_empty) begin
                sym_del_d = 1'b1;
            end
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_db_q   <= 1'b0;
            key_dbc_q  <= '0;
            del_db_q   <= 1'b0;
            del_dbc_q  <= '0;
            del_prev_q <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            gap_flag_q <= 1'b0;
            sym_we_q   <= 1'b0;
            sym_data_q <= 2'b00;
            sym_del_q  <= 1'b0;
            drop_q     <= 1'b0;
            del_pend_q <= 1'b0;
        end else begin
            key_db_q   <= key_db_d;
            key_dbc_q  <= key_dbc_d;
            del_db_q   <= del_db_d;
            del_dbc_q  <= del_dbc_d;
            del_prev_q <= del_db_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gap_flag_q <= gap_flag_d;
            sym_we_q   <= sym_we_d;
            sym_data_q <= sym_data_d;
            sym_del_q  <= sym_del_d;
            drop_q     <= drop_d;
            del_pend_q <= del_pend_d;
        end
    end

    assign sym_we   = sym_we_q;
    assign sym_data = sym_data_q;
    assign sym_del  = sym_del_q;
    assign drop     = drop_q;

`ifdef MORSE_KEYER_SIDETONE_EN
    localparam int TONE_W = (TONE_HALF_CYCLES > 1) ? $clog2(TONE_HALF_CYCLES + 1) : 1;
    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF_CYCLES - 1);

    logic              tone_q, tone_d;
    logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;

    // Sidetone square wave while the debounced key is held, silent otherwise
    always_comb begin
        tone_d     = 1'b0;
        tone_cnt_d = '0;
        if (key_db_q) begin
            tone_d = tone_q;
            if (tone_cnt_q == TONE_LAST) begin
                tone_d = ~tone_q;
            end else begin
                tone_cnt_d = tone_cnt_q + TONE_W'(1);
            end
        end
    end

    // Sidetone registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tone_q     <= 1'b0;
            tone_cnt_q <= '0;
        end else begin
            tone_q     <= tone_d;
            tone_cnt_q <= tone_cnt_d;
        end
    end

    assign tone = tone_q;
`else
    assign tone = 1'b0;
`endif

endmodule

// File: doc/morse_keyer.md
Name: morse_keyer

Overview:
Upstream producer for the 2-bit symbol FIFO. Converts a raw Morse key into classified symbols: dot, dash, letter gap and word gap. Converts a raw delete button into single-cycle delete requests. Drives the FIFO write-enable, data and delete inputs, and respects its full/empty flags.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles before a debounced level changes (10 ms at 50 MHz)
DOT_MAX_CYCLES, 12500000, press shorter than this is a dot, otherwise a dash
LETTER_GAP_CYCLES, 25000000, release length that emits a letter gap
WORD_GAP_CYCLES, 75000000, release length that emits a word gap; must exceed LETTER_GAP_CYCLES
CNT_W, 27, width of the duration counter; must hold WORD_GAP_CYCLES

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
key  input  1  raw Morse key, 1 = pressed, asynchronous to clk
del_key  input  1  raw delete button, 1 = pressed, asynchronous
fifo_full  input  1  FIFO full flag
fifo_empty  input  1  FIFO empty flag
sym_we  output  1  one-cycle FIFO write strobe
sym_data  output  2  symbol, valid only while sym_we=1
sym_del  output  1  one-cycle FIFO delete strobe
drop  output  1  one-cycle pulse: a symbol was discarded because the FIFO was full
tone  output  1  sidetone, see Optional Feature

Behaviour:
- Symbol encoding: 2'b00 dot, 2'b01 dash, 2'b10 letter gap, 2'b11 word gap.
- Reset (async assert): all outputs 0; FSM enters IDLE; counters 0; synchronisers and debounced levels 0; the letter-gap-emitted flag is cleared.
- Input path: key and del_key each pass through a 2-flop synchroniser, then a debouncer. A debounced level changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
- FSM states: IDLE, PRESS, GAP.
  - IDLE: on debounced key rise, go to PRESS with cnt=0.
  - PRESS: cnt increments, saturating at all-ones. On debounced fall, emit dot if cnt < DOT_MAX_CYCLES, else dash. Then go to GAP with cnt=0 and the gap flag cleared.
  - GAP: cnt increments. When cnt == LETTER_GAP_CYCLES-1 and the flag is clear, emit a letter gap and set the flag. When cnt == WORD_GAP_CYCLES-1, emit a word gap and go to IDLE. A debounced rise in GAP goes to PRESS with cnt=0; no gap symbol is emitted for that partial gap.
- No gap symbols are emitted from IDLE. A word gap is therefore only produced after at least one key symbol, and consecutive word gaps cannot occur.
- Emit timing: sym_we/sym_data are registered and assert on the clock edge after the triggering debounced event. Width is exactly one cycle.
- Full handling: if fifo_full=1 in the cycle an emit is decided, sym_we stays 0, drop pulses for 1 cycle, and the symbol is lost. There is no retry.
- Delete: a debounced del_key rise requests sym_del for one cycle, registered.
  - Suppressed if fifo_empty=1 in the decision cycle.
  - If the same cycle also emits a symbol, sym_we wins and sym_del is issued on the following cycle (after re-checking fifo_empty). sym_we and sym_del are never high together.
  - Holding del_key produces exactly one delete.
- Key held through reset deassertion: treated as a fresh press once the debounce completes; duration is counted from the debounced rise.
- Counter saturation: a press longer than 2^CNT_W-1 cycles is still classified as a dash.

Optional Feature:
Macro MORSE_KEYER_SIDETONE_EN. When defined, adds parameter TONE_HALF_CYCLES (default 25000, 1 kHz at 50 MHz). tone toggles every TONE_HALF_CYCLES while the debounced key is 1. tone is forced to 0 and its counter cleared while the key is released or in reset. When not defined, tone is tied to 0 and no tone counter exists.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, DOT_MAX_CYCLES=20, LETTER_GAP_CYCLES=40, WORD_GAP_CYCLES=100, CNT_W=8.)
- Dot: key high 10 cycles, then low 200 → sym_we pulses with 00, then 10 about 40 cycles after the fall, then 11 about 100 cycles after the fall; FSM returns to IDLE; no further strobes.
- Dash then letter: key high 30, low 10, high 8, low 60 → sequence 01, 00, 10; no gap symbol emitted for the 10-cycle release.
- Bounce: key toggles every 2 cycles for 20 cycles, then settles low → no sym_we.
- Full: fifo_full=1, key dot press → sym_we=0, drop=1 for exactly one cycle.
- Delete: del_key held 50 cycles with fifo_empty=0 → exactly one sym_del pulse. Repeat with fifo_empty=1 → no pulse. Force a delete coinciding with an emit → sym_del one cycle after sym_we.
- Reset mid-press: assert rst during PRESS at cnt=15 → all outputs 0 immediately; after release with key low, no symbol is emitted.
